dev_bridge_ctrl: RTL and testbench

//  Sequences CPU accesses onto the shared peripheral bus (timer/counter devices DEV0..DEVn-1).

---
 rtl/dev_bridge_pkg.sv | 33 +++
 rtl/dev_bridge_int_latch.sv | 40 ++++
 rtl/dev_bridge_ctrl.sv | 176 +++++++++++++++++
 tb/tb_dev_bridge_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/dev_bridge_pkg.sv
// Shared types and constants for the CPU-to-device bridge (dev_bridge_ctrl, int_latch).
package dev_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_RESP,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    KIND_NONE,
    KIND_DEV,
    KIND_CTRL
  } kind_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wd;
  } dev_req_t;

  localparam int unsigned DEV_WINDOW = 16;
  localparam int unsigned DEV_SHIFT  = $clog2(DEV_WINDOW);
  localparam int unsigned SEL_W      = 2;
  // Bridge register block spans IMASK, IPEND, FAULT_ADDR (+0, +4, +8).
  localparam int unsigned CTRL_SPAN  = 12;

  localparam logic [1:0] REG_IMASK = 2'd0;
  localparam logic [1:0] REG_IPEND = 2'd1;
  localparam logic [1:0] REG_FAULT = 2'd2;

endpackage

// File: rtl/dev_bridge_int_latch.sv
// Interrupt edge detect, IPEND (W1C, set wins) / IMASK registers and masked HWInt output.
module int_latch
  import dev_bridge_pkg::*;
#(
  parameter int unsigned NUM_DEV = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_DEV-1:0] intrp,
  input  logic               wr_en,
  input  logic [1:0]         wr_sel,
  input  logic [NUM_DEV-1:0] wd,
  output logic [NUM_DEV-1:0] imask,
  output logic [NUM_DEV-1:0] ipend,
  output logic [5:0]         hwint
);

  logic [NUM_DEV-1:0] intrp_q;
  logic [NUM_DEV-1:0] rise_c;
  logic [NUM_DEV-1:0] clr_c;

  // The single sync flop doubles as the previous sample for edge detection.
  assign rise_c = intrp & ~intrp_q;
  assign clr_c  = (wr_en && (wr_sel == REG_IPEND)) ? wd : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      intrp_q <= '0;
      imask   <= '0;
      ipend   <= '0;
      hwint   <= '0;
    end else begin
      intrp_q <= intrp;
      ipend   <= (ipend & ~clr_c) | rise_c;
      if (wr_en && (wr_sel == REG_IMASK)) imask <= wd;
      hwint   <= 6'(ipend & imask);
    end
  end

endmodule

// File: rtl/dev_bridge_ctrl.sv
// Sequences CPU accesses onto the shared device bus and hosts the interrupt register block.
// Optional DEV_BRIDGE_ERR_EN adds the PrErr output and the FAULT_ADDR register.
module dev_bridge_ctrl
  import dev_bridge_pkg::*;
#(
  parameter int unsigned NUM_DEV   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
  parameter logic [31:0] CTRL_ADDR = 32'h0000_7F40
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 PrReq,
  input  logic                 PrWE,
  input  logic [31:0]          PrAddr,
  input  logic [31:0]          PrWD,
  output logic [31:0]          PrRD,
  output logic                 PrReady,
`ifdef DEV_BRIDGE_ERR_EN
  output logic                 PrErr,
`endif
  output logic [31:0]          DEV_Addr,
  output logic [31:0]          DEV_WD,
  output logic [NUM_DEV-1:0]   DEV_WE,
  input  logic [32*NUM_DEV-1:0] DEV_RD,
  input  logic [NUM_DEV-1:0]   intrp,
  output logic [5:0]           HWInt
);

  state_e             state_q, state_d;
  kind_e              kind_q, kind_d, kind_c;
  logic [SEL_W-1:0]   sel_q, sel_d, sel_c;
  dev_req_t           req_q, req_d;
  logic [NUM_DEV-1:0] we_d;
  logic               ready_d;
  logic [31:0]        rd_d;
  logic [31:0]        dev_off, ctrl_off;
  logic [31:0]        dev_rd_c, ctrl_rd_c;
  logic [NUM_DEV-1:0] imask, ipend;
  logic               reg_wr;
`ifdef DEV_BRIDGE_ERR_EN
  logic [31:0]        fault_q;
  logic               err_d;
`endif

  assign DEV_Addr = req_q.addr;
  assign DEV_WD   = req_q.wd;

  // Address decode of the live request; only consumed in IDLE.
  assign dev_off  = PrAddr - BASE_ADDR;
  assign ctrl_off = PrAddr - CTRL_ADDR;

  always_comb begin
    kind_c = KIND_NONE;
    sel_c  = '0;
    if (dev_off < 32'(DEV_WINDOW * NUM_DEV)) begin
      kind_c = KIND_DEV;
      sel_c  = SEL_W'(dev_off >> DEV_SHIFT);
    end else if (ctrl_off < 32'(CTRL_SPAN)) begin
      kind_c = KIND_CTRL;
    end
  end

  always_comb begin
    dev_rd_c = '0;
    for (int unsigned i = 0; i < NUM_DEV; i++) begin
      if (sel_q == SEL_W'(i)) dev_rd_c = DEV_RD[32*i +: 32];
    end
  end

  always_comb begin
    ctrl_rd_c = '0;
    case (req_q.addr[3:2])
      REG_IMASK: ctrl_rd_c = 32'(imask);
      REG_IPEND: ctrl_rd_c = 32'(ipend);
`ifdef DEV_BRIDGE_ERR_EN
      REG_FAULT: ctrl_rd_c = fault_q;
`endif
      default:   ctrl_rd_c = '0;
    endcase
  end

  // Next-state and next-output logic; all bus outputs are registered from these.
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    sel_d   = sel_q;
    req_d   = req_q;
    we_d    = '0;
    ready_d = 1'b0;
    rd_d    = PrRD;
    case (state_q)
      ST_IDLE: begin
        if (PrReq) begin
          req_d.addr = PrAddr;
          req_d.wd   = PrWD;
          kind_d     = kind_c;
          sel_d      = sel_c;
          if (PrWE) begin
            state_d = ST_WR;
            ready_d = 1'b1;
            for (int unsigned i = 0; i < NUM_DEV; i++) begin
              we_d[i] = (kind_c == KIND_DEV) && (sel_c == SEL_W'(i));
            end
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_WR:   state_d = ST_DONE;
      ST_RD: begin
        state_d = ST_RESP;
        ready_d = 1'b1;
        case (kind_q)
          KIND_DEV:  rd_d = dev_rd_c;
          KIND_CTRL: rd_d = ctrl_rd_c;
          default:   rd_d = '0;
        endcase
      end
      ST_RESP: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      kind_q  <= KIND_NONE;
      sel_q   <= '0;
      req_q   <= '0;
      DEV_WE  <= '0;
      PrReady <= 1'b0;
      PrRD    <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      sel_q   <= sel_d;
      req_q   <= req_d;
      DEV_WE  <= we_d;
      PrReady <= ready_d;
      PrRD    <= rd_d;
    end
  end

`ifdef DEV_BRIDGE_ERR_EN
  assign err_d = ready_d && (((state_q == ST_IDLE) ? kind_c : kind_q) == KIND_NONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PrErr   <= 1'b0;
      fault_q <= '0;
    end else begin
      PrErr <= err_d;
      if (((state_q == ST_WR) || (state_q == ST_RD)) && (kind_q == KIND_NONE))
        fault_q <= req_q.addr;
    end
  end
`endif

  assign reg_wr = (state_q == ST_WR) && (kind_q == KIND_CTRL);

  int_latch #(
    .NUM_DEV (NUM_DEV)
  ) u_int_latch (
    .clk    (clk),
    .rst_n  (reset),
    .intrp  (intrp),
    .wr_en  (reg_wr),
    .wr_sel (req_q.addr[3:2]),
    .wd     (req_q.wd[NUM_DEV-1:0]),
    .imask  (imask),
    .ipend  (ipend),
    .hwint  (HWInt)
  );

endmodule

// File: tb/tb_dev_bridge_ctrl.sv
// Directed self-checking bench for dev_bridge_ctrl (default NUM_DEV=2 configuration).
module tb_dev_bridge_ctrl;

  localparam int unsigned NUM_DEV = 2;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    PrReq, PrWE;
  logic [31:0]             PrAddr, PrWD, PrRD;
  logic                    PrReady;
  logic [31:0]             DEV_Addr, DEV_WD;
  logic [NUM_DEV-1:0]      DEV_WE;
  logic [32*NUM_DEV-1:0]   DEV_RD;
  logic [NUM_DEV-1:0]      intrp;
  logic [5:0]              HWInt;
`ifdef DEV_BRIDGE_ERR_EN
  logic                    PrErr;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dev_bridge_ctrl #(
    .NUM_DEV   (NUM_DEV),
    .BASE_ADDR (32'h0000_7F00),
    .CTRL_ADDR (32'h0000_7F40)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .PrReq    (PrReq),
    .PrWE     (PrWE),
    .PrAddr   (PrAddr),
    .PrWD     (PrWD),
    .PrRD     (PrRD),
    .PrReady  (PrReady),
`ifdef DEV_BRIDGE_ERR_EN
    .PrErr    (PrErr),
`endif
    .DEV_Addr (DEV_Addr),
    .DEV_WD   (DEV_WD),
    .DEV_WE   (DEV_WE),
    .DEV_RD   (DEV_RD),
    .intrp    (intrp),
    .HWInt    (HWInt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Write transaction; mid_irq is applied to intrp in the cycle the write strobe is active.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [NUM_DEV-1:0] mid_irq,
                           output int lat, output logic [NUM_DEV-1:0] we_or,
                           output int we_n, output logic [31:0] wd_seen,
                           output logic err_seen);
    lat = 0; we_or = '0; we_n = 0; wd_seen = '0; err_seen = 1'b0;
    @(negedge clk);
    PrReq = 1'b1; PrWE = 1'b1; PrAddr = a; PrWD = d;
    for (int c = 1; c <= 6 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (DEV_WE != '0) begin we_or |= DEV_WE; we_n++; end
      if (PrReady) begin
        lat = c;
        wd_seen = DEV_WD;
`ifdef DEV_BRIDGE_ERR_EN
        err_seen = PrErr;
`endif
      end
    end
    @(negedge clk);
    PrReq = 1'b0; intrp = mid_irq;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (DEV_WE != '0) begin we_or |= DEV_WE; we_n++; end
    end
  endtask

  task automatic bus_read(input logic [31:0] a, output int lat, output logic [31:0] rd_seen,
                          output int we_n, output logic err_seen);
    lat = 0; rd_seen = '0; we_n = 0; err_seen = 1'b0;
    @(negedge clk);
    PrReq = 1'b1; PrWE = 1'b0; PrAddr = a; PrWD = 32'h5A5A_5A5A;
    for (int c = 1; c <= 6 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (DEV_WE != '0) we_n++;
      if (PrReady) begin
        lat = c;
        rd_seen = PrRD;
`ifdef DEV_BRIDGE_ERR_EN
        err_seen = PrErr;
`endif
      end
    end
    @(negedge clk);
    PrReq = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (DEV_WE != '0) we_n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, we_n, rdy_n;
    logic [NUM_DEV-1:0] we_or;
    logic [31:0] wd_seen, rd_seen;
    logic err_seen;

    reset = 1'b0; PrReq = 1'b0; PrWE = 1'b0; PrAddr = '0; PrWD = '0;
    intrp = '0;
    DEV_RD = {32'hDEAD_BEEF, 32'h1111_1111};
    repeat (3) @(posedge clk);
    #1;
    check("rst_prready", 32'(PrReady), 32'd0);
    check("rst_prrd", PrRD, 32'd0);
    check("rst_dev_we", 32'(DEV_WE), 32'd0);
    check("rst_hwint", 32'(HWInt), 32'd0);
    @(negedge clk); reset = 1'b1;
    repeat (2) @(posedge clk);

    // 1: device 0 write
    bus_write(32'h0000_7F00, 32'h0000_0009, intrp, lat, we_or, we_n, wd_seen, err_seen);
    check("wr0_latency", 32'(lat), 32'd1);
    check("wr0_we", 32'(we_or), 32'h1);
    check("wr0_we_cycles", 32'(we_n), 32'd1);
    check("wr0_wd", wd_seen, 32'h9);
    check("wr0_addr", DEV_Addr, 32'h0000_7F00);

    // 2: device reads
    bus_read(32'h0000_7F14, lat, rd_seen, we_n, err_seen);
    check("rd1_latency", 32'(lat), 32'd2);
    check("rd1_data", rd_seen, 32'hDEAD_BEEF);
    check("rd1_no_we", 32'(we_n), 32'd0);
    bus_read(32'h0000_7F0C, lat, rd_seen, we_n, err_seen);
    check("rd0_data", rd_seen, 32'h1111_1111);

    // 3: IMASK, interrupt latch, W1C
    bus_write(32'h0000_7F40, 32'hFFFF_FFFF, intrp, lat, we_or, we_n, wd_seen, err_seen);
    check("imask_wr_no_we", 32'(we_n), 32'd0);
    bus_read(32'h0000_7F40, lat, rd_seen, we_n, err_seen);
    check("imask_upper_bits", rd_seen, 32'h3);
    @(negedge clk); intrp = 2'b01;
    @(posedge clk); @(posedge clk); #1;
    check("hwint_set", 32'(HWInt), 32'h01);
    bus_read(32'h0000_7F44, lat, rd_seen, we_n, err_seen);
    check("ipend_set", rd_seen, 32'h1);
    bus_write(32'h0000_7F44, 32'h1, intrp, lat, we_or, we_n, wd_seen, err_seen);
    check("hwint_w1c", 32'(HWInt), 32'h0);
    bus_read(32'h0000_7F44, lat, rd_seen, we_n, err_seen);
    check("ipend_held_high", rd_seen, 32'h0);

    // 4: rising edge on intrp[1] in the same cycle as its W1C
    bus_write(32'h0000_7F44, 32'h2, 2'b11, lat, we_or, we_n, wd_seen, err_seen);
    check("set_wins_hwint", 32'(HWInt), 32'h02);
    bus_read(32'h0000_7F44, lat, rd_seen, we_n, err_seen);
    check("set_wins_ipend", rd_seen, 32'h2);

    // 5: unmapped accesses
    bus_read(32'h0000_7F80, lat, rd_seen, we_n, err_seen);
    check("unmap_rd_latency", 32'(lat), 32'd2);
    check("unmap_rd_data", rd_seen, 32'h0);
    check("unmap_rd_no_we", 32'(we_n), 32'd0);
`ifdef DEV_BRIDGE_ERR_EN
    check("unmap_rd_err", 32'(err_seen), 32'd1);
    bus_read(32'h0000_7F48, lat, rd_seen, we_n, err_seen);
    check("fault_addr", rd_seen, 32'h0000_7F80);
    check("fault_rd_no_err", 32'(err_seen), 32'd0);
`else
    bus_read(32'h0000_7F48, lat, rd_seen, we_n, err_seen);
    check("ctrl8_reads_zero", rd_seen, 32'h0);
`endif
    bus_write(32'h0000_7F20, 32'h1234_5678, intrp, lat, we_or, we_n, wd_seen, err_seen);
    check("unmap_wr_latency", 32'(lat), 32'd1);
    check("unmap_wr_no_we", 32'(we_n), 32'd0);
`ifdef DEV_BRIDGE_ERR_EN
    check("unmap_wr_err", 32'(err_seen), 32'd1);
`endif

    // 6: reset during a read
    intrp = '0;
    @(negedge clk);
    PrReq = 1'b1; PrWE = 1'b0; PrAddr = 32'h0000_7F14;
    @(posedge clk); #1;
    check("mid_rd_not_ready", 32'(PrReady), 32'd0);
    @(negedge clk); reset = 1'b0; PrReq = 1'b0;
    #1;
    check("async_rst_addr", DEV_Addr, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    rdy_n = 0; we_n = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (PrReady) rdy_n++;
      if (DEV_WE != '0) we_n++;
    end
    check("post_rst_no_ready", 32'(rdy_n), 32'd0);
    check("post_rst_no_we", 32'(we_n), 32'd0);
    check("post_rst_prrd", PrRD, 32'h0);
    check("post_rst_dev_wd", DEV_WD, 32'h0);
    check("post_rst_hwint", 32'(HWInt), 32'h0);
    bus_write(32'h0000_7F10, 32'h5, intrp, lat, we_or, we_n, wd_seen, err_seen);
    check("post_rst_wr_latency", 32'(lat), 32'd1);
    check("post_rst_wr_we", 32'(we_or), 32'h2);
    check("post_rst_wr_wd", wd_seen, 32'h5);
    bus_read(32'h0000_7F40, lat, rd_seen, we_n, err_seen);
    check("post_rst_imask", rd_seen, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
